// File: rtl/interrupt_ctrl_8051.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_ctrl_8051: 8051 interrupt masking, two-level priority, vectoring |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module interrupt_ctrl_8051 #(
  parameter int          NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0003,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         sfr_ie,
  input  logic [7:0]         sfr_ip,
  input  logic [7:0]         sfr_tcon,
  input  logic [NUM_SRC-1:0] src_flags,
  input  logic               cpu_ack,
  input  logic               reti,
  output logic               int_req,
  output logic [15:0]        int_vector,
  output logic               int_level,
  output logic [NUM_SRC-1:0] int_ack,
  output logic               isr_hi,
  output logic               isr_lo
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic               int_req_q, int_req_d;
  logic [15:0]        int_vector_q, int_vector_d;
  logic               int_level_q, int_level_d;
  logic [NUM_SRC-1:0] int_ack_q, int_ack_d;
  logic               isr_hi_q, isr_hi_d;
  logic               isr_lo_q, isr_lo_d;

  logic [NUM_SRC-1:0] pend, elig, hi_elig, pick, hw_clear;
  logic [IDX_W-1:0]   cand_idx;
  logic               unused_sfr_bits;

  // Only some bits of the SFRs are meaningful here.
  assign unused_sfr_bits = ^{sfr_ie, sfr_ip, sfr_tcon};

  always_comb begin
    pend     = src_flags & sfr_ie[NUM_SRC-1:0] & {NUM_SRC{sfr_ie[7]}};
    elig     = isr_hi_q ? '0 : (isr_lo_q ? (pend & sfr_ip[NUM_SRC-1:0]) : pend);
    hi_elig  = elig & sfr_ip[NUM_SRC-1:0];
    pick     = (|hi_elig) ? hi_elig : elig;
    cand_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pick[i]) cand_idx = IDX_W'(i);
    end
    // Timer flags are always cleared by hardware; externals only when edge-triggered.
    hw_clear = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (i)
        0:       hw_clear[i] = sfr_tcon[0];
        1, 3:    hw_clear[i] = 1'b1;
        2:       hw_clear[i] = sfr_tcon[2];
        default: hw_clear[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_idx_d    = sel_idx_q;
    int_req_d    = int_req_q;
    int_vector_d = int_vector_q;
    int_level_d  = int_level_q;
    int_ack_d    = '0;
    isr_hi_d     = isr_hi_q;
    isr_lo_d     = isr_lo_q;

    if (reti) begin
      if (isr_hi_q) isr_hi_d = 1'b0;
      else          isr_lo_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          sel_idx_d    = cand_idx;
          int_level_d  = sfr_ip[cand_idx];
          int_vector_d = VECTOR_BASE + VECTOR_STRIDE * 16'(cand_idx);
          int_req_d    = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (cpu_ack) begin
          int_req_d = 1'b0;
          state_d   = S_IDLE;
          if (int_level_q) isr_hi_d = 1'b1;
          else             isr_lo_d = 1'b1;
          if (hw_clear[sel_idx_q]) int_ack_d[sel_idx_q] = 1'b1;
        end else if (!pend[sel_idx_q]) begin
          int_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_idx_q    <= '0;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
      int_level_q  <= 1'b0;
      int_ack_q    <= '0;
      isr_hi_q     <= 1'b0;
      isr_lo_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_idx_q    <= sel_idx_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
      int_level_q  <= int_level_d;
      int_ack_q    <= int_ack_d;
      isr_hi_q     <= isr_hi_d;
      isr_lo_q     <= isr_lo_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;
  assign int_level  = int_level_q;
  assign int_ack    = int_ack_q;
  assign isr_hi     = isr_hi_q;
  assign isr_lo     = isr_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ctrl_8051.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interrupt_ctrl_8051: vector table, corner sequences, random vs model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_interrupt_ctrl_8051;

  logic        clock, reset, cpu_ack, reti;
  logic [7:0]  sfr_ie, sfr_ip, sfr_tcon;
  logic [4:0]  src_flags;
  logic        int_req, int_level, isr_hi, isr_lo;
  logic [15:0] int_vector;
  logic [4:0]  int_ack;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_ctrl_8051 dut (
    .clock(clock), .reset(reset), .sfr_ie(sfr_ie), .sfr_ip(sfr_ip),
    .sfr_tcon(sfr_tcon), .src_flags(src_flags), .cpu_ack(cpu_ack), .reti(reti),
    .int_req(int_req), .int_vector(int_vector), .int_level(int_level),
    .int_ack(int_ack), .isr_hi(isr_hi), .isr_lo(isr_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: outstanding request plus a stack of in-service levels.
  bit          m_req;
  int          m_idx;
  bit          m_lvl;
  logic [15:0] m_vec;
  logic [4:0]  m_ack;
  int          stack[$];

  function automatic bit hw_cleared(int idx);
    case (idx)
      0:       return sfr_tcon[0];
      1, 3:    return 1'b1;
      2:       return sfr_tcon[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit in_service(int lvl);
    foreach (stack[k]) if (stack[k] == lvl) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [4:0] pend;
    int  cur, cidx;
    bit  found, accept;
    if (reset) begin
      m_req = 0; m_idx = 0; m_lvl = 0; m_vec = 16'h0; m_ack = 5'h0;
      stack.delete();
      return;
    end
    pend = src_flags & sfr_ie[4:0] & {5{sfr_ie[7]}};
    cur = -1;
    foreach (stack[k]) if (stack[k] > cur) cur = stack[k];
    m_ack = 5'h0; accept = 0; found = 0; cidx = 0;
    if (!m_req) begin
      for (int lvl = 1; lvl >= 0; lvl--)
        for (int i = 0; i < 5; i++)
          if (!found && pend[i] && int'(sfr_ip[i]) == lvl && lvl > cur) begin
            found = 1; cidx = i;
          end
      if (found) begin
        m_req = 1; m_idx = cidx; m_lvl = sfr_ip[cidx];
        m_vec = 16'h0003 + 16'(8 * cidx);
      end
    end else if (cpu_ack) begin
      accept = 1; m_req = 0;
      if (hw_cleared(m_idx)) m_ack = 5'(1 << m_idx);
    end else if (!pend[m_idx]) begin
      m_req = 0;
    end
    if (reti && stack.size() > 0) void'(stack.pop_back());
    if (accept) stack.push_back(int'(m_lvl));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  ie, ip, tcon;
    logic [4:0]  flags;
    logic        ack, rti;
    logic        e_req;
    logic [15:0] e_vec;
    logic        e_lvl;
    logic [4:0]  e_ack;
    logic        e_hi, e_lo;
  } vec_t;

  function automatic vec_t row(logic rs, logic [7:0] e, logic [7:0] p, logic [7:0] t,
                               logic [4:0] f, logic a, logic rt, logic er,
                               logic [15:0] ev, logic el, logic [4:0] ea,
                               logic eh, logic elo);
    vec_t v;
    v.rst = rs; v.ie = e; v.ip = p; v.tcon = t; v.flags = f; v.ack = a; v.rti = rt;
    v.e_req = er; v.e_vec = ev; v.e_lvl = el; v.e_ack = ea; v.e_hi = eh; v.e_lo = elo;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1; cpu_ack = 0; reti = 0;
    sfr_ie = 0; sfr_ip = 0; sfr_tcon = 0; src_flags = 0;

    //               rst ie     ip     tcon   flags     ack rti  req vec      lvl ack       hi lo
    tbl.push_back(row(1, 8'h00, 8'h00, 8'h00, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // TF0 service at low level
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00010, 0, 0,   1, 16'h000B, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00010, 0, 0,   1, 16'h000B, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00010, 1, 0,   0, 16'h0000, 0, 5'b00010, 0, 1));
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 1));
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00000, 0, 1,   0, 16'h0000, 0, 5'b00000, 0, 0));
    tbl.push_back(row(1, 8'h00, 8'h00, 8'h00, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // Priority: high-level TF1 beats IE0, IE0 blocked until reti
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b01001, 0, 0,   1, 16'h001B, 1, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b01001, 1, 0,   0, 16'h0000, 0, 5'b01000, 1, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b00001, 0, 0,   0, 16'h0000, 0, 5'b00000, 1, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b00001, 0, 0,   0, 16'h0000, 0, 5'b00000, 1, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b00001, 0, 1,   0, 16'h0000, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b00001, 0, 0,   1, 16'h0003, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h9F, 8'h08, 8'h00, 5'b00001, 1, 0,   0, 16'h0000, 0, 5'b00000, 0, 1));
    tbl.push_back(row(1, 8'h00, 8'h00, 8'h00, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // Nesting: high IE1 over low TF0
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00010, 0, 0,   1, 16'h000B, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00010, 1, 0,   0, 16'h0000, 0, 5'b00010, 0, 1));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00100, 0, 0,   1, 16'h0013, 1, 5'b00000, 0, 1));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00100, 1, 0,   0, 16'h0000, 0, 5'b00100, 1, 1));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 1, 1));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00000, 0, 1,   0, 16'h0000, 0, 5'b00000, 0, 1));
    tbl.push_back(row(0, 8'h86, 8'h04, 8'h04, 5'b00000, 0, 1,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // Serial source: vector 0x23, never hardware-cleared
    tbl.push_back(row(0, 8'h90, 8'h00, 8'h05, 5'b10000, 0, 0,   1, 16'h0023, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h90, 8'h00, 8'h05, 5'b10000, 1, 0,   0, 16'h0000, 0, 5'b00000, 0, 1));
    tbl.push_back(row(0, 8'h90, 8'h00, 8'h05, 5'b00000, 0, 1,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // Withdraw: EA dropped while requesting
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00010, 0, 0,   1, 16'h000B, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h02, 8'h00, 8'h00, 5'b00010, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h02, 8'h00, 8'h00, 5'b00010, 1, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    // Reset while requesting
    tbl.push_back(row(0, 8'h82, 8'h00, 8'h00, 5'b00010, 0, 0,   1, 16'h000B, 0, 5'b00000, 0, 0));
    tbl.push_back(row(1, 8'h82, 8'h00, 8'h00, 5'b00010, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));
    tbl.push_back(row(0, 8'h00, 8'h00, 8'h00, 5'b00000, 0, 0,   0, 16'h0000, 0, 5'b00000, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; sfr_ie = tbl[k].ie; sfr_ip = tbl[k].ip; sfr_tcon = tbl[k].tcon;
      src_flags = tbl[k].flags; cpu_ack = tbl[k].ack; reti = tbl[k].rti;
      cycle();
      chk($sformatf("row%0d int_req", k), 16'(int_req), 16'(tbl[k].e_req));
      if (tbl[k].e_req || tbl[k].rst) chk($sformatf("row%0d int_vector", k), int_vector, tbl[k].e_vec);
      if (tbl[k].e_req || tbl[k].rst) chk($sformatf("row%0d int_level", k), 16'(int_level), 16'(tbl[k].e_lvl));
      chk($sformatf("row%0d int_ack", k), 16'(int_ack), 16'(tbl[k].e_ack));
      chk($sformatf("row%0d isr_hi", k), 16'(isr_hi), 16'(tbl[k].e_hi));
      chk($sformatf("row%0d isr_lo", k), 16'(isr_lo), 16'(tbl[k].e_lo));
    end

    // reti and cpu_ack together: low level released, high level set
    reset = 1; cpu_ack = 0; reti = 0; cycle();
    reset = 0; sfr_ie = 8'h86; sfr_ip = 8'h04; sfr_tcon = 8'h04; src_flags = 5'b00010;
    cycle();
    chk("both int_req", 16'(int_req), 16'd1);
    cpu_ack = 1; cycle();
    cpu_ack = 0; src_flags = 5'b00100; cycle();
    chk("both isr_lo", 16'(isr_lo), 16'd1);
    chk("both vec", int_vector, 16'h0013);
    cpu_ack = 1; reti = 1; cycle();
    cpu_ack = 0; reti = 0;
    chk("both hi", 16'(isr_hi), 16'd1);
    chk("both lo", 16'(isr_lo), 16'd0);
    chk("both ack", 16'(int_ack), 16'h0004);
    cycle();
    chk("both ack gone", 16'(int_ack), 16'h0000);

    // Random traffic against the reference model
    reset = 1; cycle();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0)
        sfr_ie = {($urandom_range(0, 7) != 0), 2'b00, 5'($urandom)};
      if ($urandom_range(0, 15) == 0) sfr_ip = 8'($urandom);
      if ($urandom_range(0, 15) == 0) sfr_tcon = 8'($urandom);
      if ($urandom_range(0, 3) == 0) src_flags = 5'($urandom);
      cpu_ack = ($urandom_range(0, 2) == 0);
      reti    = ($urandom_range(0, 5) == 0);
      cycle();
      chk("rnd int_req", 16'(int_req), 16'(m_req));
      if (m_req) begin
        chk("rnd int_vector", int_vector, m_vec);
        chk("rnd int_level", 16'(int_level), 16'(m_lvl));
      end
      chk("rnd int_ack", 16'(int_ack), 16'(m_ack));
      chk("rnd isr_hi", 16'(isr_hi), 16'(in_service(1)));
      chk("rnd isr_lo", 16'(isr_lo), 16'(in_service(0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_ctrl_8051.md
Name: interrupt_ctrl_8051

Overview:
- Interrupt controller for the 8051 core.
- Receives the request flags raised by the peripherals (IE0, TF0, IE1, TF1, serial RI|TI).
- Applies IE/IP masking and priority, then requests the CPU with a vector.
- On CPU acceptance, returns the per-source int_ack pulse that clears hardware-cleared flags in the timer and external-interrupt blocks.
- Tracks two nesting levels until RETI.

Parameters:
- NUM_SRC, 5, number of interrupt sources; index 0 has the highest natural priority.
- VECTOR_BASE, 16'h0003, vector address of source 0.
- VECTOR_STRIDE, 16'h0008, address step between consecutive source vectors.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sfr_ie  input  8  IE SFR; bit7 = EA, bits[4:0] = per-source enables
- sfr_ip  input  8  IP SFR; bits[4:0] = 1 selects high priority for that source
- sfr_tcon  input  8  TCON SFR; bit0 = IT0, bit2 = IT1 (1 = edge-triggered)
- src_flags  input  5  {RI|TI, TF1, IE1, TF0, IE0}, level flags from peripherals
- cpu_ack  input  1  one-cycle pulse: CPU has accepted the current request and started the LCALL
- reti  input  1  one-cycle pulse: CPU executed RETI
- int_req  output  1  interrupt request to the CPU
- int_vector  output  16  vector of the requested source; valid while int_req = 1
- int_level  output  1  priority level of the request (1 = high)
- int_ack  output  5  one-cycle clear pulse per source
- isr_hi  output  1  high-level service in progress
- isr_lo  output  1  low-level service in progress

Behaviour:
- Reset (sync): state = IDLE; int_req = 0, int_vector = 0, int_level = 0, int_ack = 0, isr_hi = 0, isr_lo = 0.
- Pending: pend[i] = src_flags[i] & sfr_ie[i] & sfr_ie[7].
- Eligibility:
  - isr_hi = 1: nothing is eligible.
  - isr_lo = 1 only: only pending sources with ip = 1 are eligible.
  - Neither set: all pending sources are eligible.
- Selection:
  - Any eligible high-priority source wins over any low-priority one.
  - Within the same level, the lowest index wins.
- FSM IDLE:
  - If any source is eligible, latch sel_idx, int_level = ip[sel_idx], int_vector = VECTOR_BASE + sel_idx*VECTOR_STRIDE.
  - Set int_req = 1 and go to REQ. All of these are registered, so int_req rises 1 cycle after the flag is seen.
  - cpu_ack in IDLE is ignored.
- FSM REQ:
  - int_req, int_vector and int_level are held stable. A newly arriving higher-priority source does not preempt a latched request.
  - If pend[sel_idx] falls before cpu_ack (flag cleared by software, or disabled): int_req = 0 next cycle, return to IDLE, no int_ack.
  - On cpu_ack:
    - int_req = 0 next cycle.
    - Set isr_hi if int_level = 1, else isr_lo.
    - Pulse int_ack[sel_idx] for exactly 1 cycle (the cycle after cpu_ack), but only for hardware-cleared sources: TF0 and TF1 always; IE0 only if IT0 = 1; IE1 only if IT1 = 1; the serial source never.
    - Return to IDLE. No new request is issued in the same cycle int_ack is high.
- reti:
  - Clears isr_hi if it is set, otherwise clears isr_lo.
  - reti with neither bit set: no effect.
- reti and cpu_ack in the same cycle: the reti clear is applied first, then the set for the new acceptance.
- int_ack width follows src_flags; no other output pulses.
- Reset mid-REQ: request dropped, no int_ack, both in-service bits cleared.
- All vector arithmetic is 16-bit with no overflow for NUM_SRC = 5; vectors are 0x0003, 0x000B, 0x0013, 0x001B, 0x0023.

Test Plan:
- TF0 service: IE = 0x82, IP = 0, TF0 = 1 at cycle N.
  - int_req = 1 at N+1 with int_vector = 0x000B, int_level = 0.
  - cpu_ack at N+3: int_ack = 5'b00010 at N+4 only; int_req = 0 at N+4; isr_lo = 1.
- Priority order: IE = 0x9F, IP = 0x08, IE0 and TF1 both set → int_vector = 0x001B, int_level = 1.
  - After cpu_ack: isr_hi = 1 and IE0 is blocked until reti.
  - After reti: isr_hi = 0, and the IE0 request (vector 0x0003) follows.
- Nesting: low-priority TF0 in service (isr_lo = 1).
  - IE1 (IP[2] = 1, IT1 = 1) raised → int_req with vector 0x0013, level 1.
  - Ack: int_ack = 5'b00100, isr_hi = 1, isr_lo = 1.
  - First reti clears isr_hi only; second reti clears isr_lo.
- Level-triggered and serial sources get no int_ack:
  - IT0 = 0, IE0 accepted → int_ack = 0.
  - Serial source accepted → vector 0x0023, int_ack = 0.
- Withdraw: EA cleared while in REQ before cpu_ack → int_req = 0 next cycle, no int_ack, isr bits unchanged.
- Reset: reset asserted during REQ → next cycle int_req = 0, isr_hi = 0, isr_lo = 0, int_vector = 0.
